preif_fetch_ctrl: RTL and testbench
===================================

PREIF_FETCH_CTRL -- requirements
Module: preif_fetch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'hbfc00000, address of the first fetch after reset.
REQ-002 SHALL have ports:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-high; clears all state immediately
  flush  in  1  exception/ERET redirect pulse
  flush_target  in  32  redirect PC for flush
  br_taken  in  1  branch redirect pulse
  br_target  in  32  redirect PC for branch
  fs_allowin  in  1  downstream stage accepts an instruction this cycle
  fs_valid  out  1  buffer head holds a valid instruction
  fs_pc  out  32  PC of buffer head
  fs_inst  out  32  instruction of buffer head
  inst_sram_req  out  1  request valid
  inst_sram_wr  out  1  constant 0
  inst_sram_size  out  2  constant 2'd2 (4 bytes)
  inst_sram_wstrb  out  4  constant 4'h0
  inst_sram_addr  out  32  request address
  inst_sram_wdata  out  32  constant 0
  inst_sram_addr_ok  in  1  request accepted (req & addr_ok)
  inst_sram_data_ok  in  1  one read response returned, in request order
  inst_sram_rdata  in  32  response data, valid with data_ok

Function
REQ-003 SHALL treat "accept" as inst_sram_req & inst_sram_addr_ok in the same cycle.
REQ-004 SHALL hold inst_sram_req high and inst_sram_addr unchanged from assertion until accept; redirects SHALL NOT alter a pending unaccepted request.
REQ-005 SHALL keep outstanding counter oc (0..2): +1 on accept, -1 on data_ok, both same cycle -> unchanged.
REQ-006 SHALL keep a 2-entry in-order PC queue of accepted addresses; push on accept, pop on data_ok.
REQ-007 SHALL keep a 2-entry instruction FIFO {pc, inst}, count bc (0..2).
REQ-008 SHALL assert a new request only when registered oc + bc < 2 and no request pending; same-cycle pop/data_ok SHALL NOT be counted.
REQ-009 SHALL issue at next_pc; next_pc += 4 on each accept (32-bit wrap, 32'hfffffffc -> 0).
REQ-010 SHALL accept redirect when flush or br_taken; flush has priority over br_taken in the same cycle.
REQ-011 On redirect SHALL: next_pc <= target; FIFO cleared (bc=0); drop counter dc <= number of accepted-but-unreturned requests after this cycle's accept/data_ok; a pending unaccepted request is marked stale.
REQ-012 Stale request accept SHALL increment dc and SHALL NOT advance next_pc; the following request uses the redirect target.
REQ-013 On data_ok with dc>0 SHALL decrement dc and discard rdata; else push {queue head pc, rdata} into FIFO.
REQ-014 fs_valid SHALL equal bc != 0; fs_pc/fs_inst SHALL present FIFO head; pop on fs_valid & fs_allowin & no redirect.
REQ-015 Latency: data_ok in cycle T -> fs_valid earliest T+1; no combinational path from inst_sram_rdata to fs_inst.
REQ-016 data_ok with oc==0 is illegal; behaviour unspecified, bench SHALL flag it.
REQ-017 Redirect in the same cycle as data_ok SHALL discard that data (counted in dc computation of REQ-011).

Reset
REQ-018 During reset: inst_sram_req=0, fs_valid=0, oc=bc=dc=0, stale=0, next_pc=RESET_PC, inst_sram_addr=RESET_PC.
REQ-019 First request SHALL assert in the first rising edge after reset deasserts, address RESET_PC.
REQ-020 Reset asserted mid-transfer SHALL abandon all outstanding requests; responses after reset are ignored by the environment.

Verification
REQ-021 Reset release, addr_ok=1, data_ok one cycle after accept, fs_allowin=1 -> fetches bfc00000, bfc00004, bfc00008 in order on fs_pc with matching fs_inst.
REQ-022 fs_allowin=0 for 10 cycles -> exactly 2 requests accepted, bc=2, req stays low until first pop.
REQ-023 br_taken target 80001000 with 2 outstanding -> both responses dropped, next fs_pc = 80001000.
REQ-024 br_taken while req pending with addr_ok=0 for 3 cycles -> addr held at old PC, its data dropped, next request 80001000.
REQ-025 flush (target bfc00380) and br_taken same cycle -> next fs_pc = bfc00380.
REQ-026 Random addr_ok/data_ok delays 0-5 cycles, random redirects, 10k cycles -> fs_pc sequence matches reference PC model, oc never exceeds 2.

Source files
------------

// File: rtl/preif_fetch_ctrl.sv
// Instruction-fetch front end: issues in-order SRAM reads, tracks outstanding
// responses and buffers up to two fetched instructions for the decode stage.
module preif_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        fs_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  logic        req_q, stale;
  logic [31:0] addr_q, next_pc;
  logic [1:0]  oc, bc, dc;
  logic [31:0] pcq [2];
  logic [31:0] fq_pc [2];
  logic [31:0] fq_inst [2];

  logic        req_n, stale_n;
  logic [31:0] addr_n, next_pc_n;
  logic [1:0]  oc_n, bc_n, dc_n;
  logic [31:0] pcq_n [2];
  logic [31:0] fq_pc_n [2];
  logic [31:0] fq_inst_n [2];

  logic        accept, redirect, drop, push, pop;
  logic [31:0] target;
  logic [1:0]  pcq_wr, fq_wr;

  assign accept   = req_q & inst_sram_addr_ok;
  assign redirect = flush | br_taken;
  assign target   = flush ? flush_target : br_target;
  assign drop     = inst_sram_data_ok & (dc != 2'd0);
  assign push     = inst_sram_data_ok & ~drop & ~redirect;
  assign pop      = (bc != 2'd0) & fs_allowin & ~redirect;

  always_comb begin
    oc_n   = oc + 2'(accept) - 2'(inst_sram_data_ok);
    pcq_wr = oc - 2'(inst_sram_data_ok);
    fq_wr  = bc - 2'(pop);

    pcq_n[0] = pcq[0];
    pcq_n[1] = pcq[1];
    if (inst_sram_data_ok) pcq_n[0] = pcq[1];
    if (accept) pcq_n[pcq_wr[0]] = addr_q;

    fq_pc_n[0]   = fq_pc[0];
    fq_pc_n[1]   = fq_pc[1];
    fq_inst_n[0] = fq_inst[0];
    fq_inst_n[1] = fq_inst[1];
    if (pop) begin
      fq_pc_n[0]   = fq_pc[1];
      fq_inst_n[0] = fq_inst[1];
    end
    if (push) begin
      fq_pc_n[fq_wr[0]]   = pcq[0];
      fq_inst_n[fq_wr[0]] = inst_sram_rdata;
    end

    bc_n = redirect ? 2'd0 : bc + 2'(push) - 2'(pop);
    // On redirect every request still in flight after this edge is garbage.
    dc_n = redirect ? oc_n : dc - 2'(drop) + 2'(accept & stale);
    stale_n   = redirect ? (req_q & ~accept) : (stale & ~accept);
    next_pc_n = redirect ? target : ((accept & ~stale) ? next_pc + 32'd4 : next_pc);

    req_n  = req_q & ~accept;
    addr_n = addr_q;
    if (!req_q && (({1'b0, oc} + {1'b0, bc}) < 3'd2)) begin
      req_n  = 1'b1;
      addr_n = redirect ? target : next_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      stale      <= 1'b0;
      addr_q     <= RESET_PC;
      next_pc    <= RESET_PC;
      oc         <= 2'd0;
      bc         <= 2'd0;
      dc         <= 2'd0;
      pcq[0]     <= 32'd0;
      pcq[1]     <= 32'd0;
      fq_pc[0]   <= 32'd0;
      fq_pc[1]   <= 32'd0;
      fq_inst[0] <= 32'd0;
      fq_inst[1] <= 32'd0;
    end else begin
      req_q      <= req_n;
      stale      <= stale_n;
      addr_q     <= addr_n;
      next_pc    <= next_pc_n;
      oc         <= oc_n;
      bc         <= bc_n;
      dc         <= dc_n;
      pcq[0]     <= pcq_n[0];
      pcq[1]     <= pcq_n[1];
      fq_pc[0]   <= fq_pc_n[0];
      fq_pc[1]   <= fq_pc_n[1];
      fq_inst[0] <= fq_inst_n[0];
      fq_inst[1] <= fq_inst_n[1];
    end
  end

  assign inst_sram_req   = req_q;
  assign inst_sram_addr  = addr_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'd0;
  assign fs_valid        = (bc != 2'd0);
  assign fs_pc           = fq_pc[0];
  assign fs_inst         = fq_inst[0];

endmodule

// File: tb/tb_preif_fetch_ctrl.sv
// Bench for preif_fetch_ctrl: a cycle-exact directed vector table, then an
// in-order SRAM responder with a sequential-PC reference model.
module tb_preif_fetch_ctrl;
  localparam logic [31:0] B = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush, br_taken, fs_allowin;
  logic [31:0] flush_target, br_target;
  logic        fs_valid;
  logic [31:0] fs_pc, fs_inst;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  always #5 clk = ~clk;

  preif_fetch_ctrl #(.RESET_PC(B)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_target(flush_target),
    .br_taken(br_taken), .br_target(br_target), .fs_allowin(fs_allowin),
    .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  typedef struct {
    logic        fl, br;
    logic [31:0] ft, bt;
    logic        allow, aok, dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(input logic fl, input logic br, input logic [31:0] ft,
                              input logic [31:0] bt, input logic allow, input logic aok,
                              input logic dok, input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic e_fv,
                              input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.fl = fl; v.br = br; v.ft = ft; v.bt = bt; v.allow = allow; v.aok = aok;
    v.dok = dok; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
    v.e_fv = e_fv; v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  // responder / reference model state
  logic [31:0] respq[$];
  int          wait_cnt, dly_min, dly_max, aok_pct, redir_pct;
  int          pops, accepts, max_out;
  bit          allow, allow_rnd;
  bit          rd_flush, rd_br;
  logic [31:0] rd_ft, rd_bt, exp_pc;

  task automatic do_reset();
    flush = 0; br_taken = 0; flush_target = 0; br_target = 0; fs_allowin = 0;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 0;
    reset = 1'b1;
    #1;
    check("rst_req", {31'b0, inst_sram_req}, 32'd0);
    check("rst_fv", {31'b0, fs_valid}, 32'd0);
    check("rst_addr", inst_sram_addr, B);
    respq.delete();
    wait_cnt = 0; pops = 0; accepts = 0; max_out = 0; exp_pc = B;
    rd_flush = 0; rd_br = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle of responder + model; called at a negedge.
  task automatic tick();
    bit acc, dok, redir, al;
    logic [31:0] tgt;
    inst_sram_addr_ok = ($urandom_range(0, 99) < aok_pct);
    dok = (respq.size() != 0) && (wait_cnt == 0);
    inst_sram_data_ok = dok;
    inst_sram_rdata = dok ? mem(respq[0]) : 32'hdeadbeef;
    if (redir_pct != 0 && $urandom_range(0, 99) < redir_pct) begin
      rd_flush = 1'($urandom_range(0, 1));
      rd_br    = 1'($urandom_range(0, 1));
      rd_ft    = $urandom & 32'hfffffffc;
      rd_bt    = $urandom & 32'hfffffffc;
    end
    al = allow_rnd ? 1'($urandom_range(0, 1)) : allow;
    flush = rd_flush; br_taken = rd_br; flush_target = rd_ft; br_target = rd_bt;
    fs_allowin = al;
    redir = rd_flush | rd_br;
    tgt = rd_flush ? rd_ft : rd_bt;
    acc = inst_sram_req & inst_sram_addr_ok;
    if (acc) begin
      respq.push_back(inst_sram_addr);
      accepts++;
    end
    if (dok) begin
      void'(respq.pop_front());
      wait_cnt = $urandom_range(dly_min, dly_max);
    end else if (respq.size() != 0 && wait_cnt > 0) begin
      wait_cnt--;
    end
    if (respq.size() > max_out) max_out = respq.size();
    if (fs_valid && al && !redir) begin
      check("pop_pc", fs_pc, exp_pc);
      check("pop_inst", fs_inst, mem(exp_pc));
      exp_pc += 32'd4;
      pops++;
    end
    if (redir) exp_pc = tgt;
    rd_flush = 0; rd_br = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, budget;
    // fl br ft bt allow aok dok rdata | req addr fv pc inst
    vec.push_back(mk(0,0,0,0, 1,1,0,0,                    0,B,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,1,0,0,                    1,B,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,1,1,mem(B),               0,B,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,1,0,0,                    1,B+4,1,B,mem(B)));
    vec.push_back(mk(0,0,0,0, 1,1,1,mem(B+4),             0,B+4,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,1,0,0,                    1,B+8,1,B+4,mem(B+4)));
    vec.push_back(mk(0,0,0,0, 1,1,1,mem(B+8),             0,B+8,0,0,0));
    vec.push_back(mk(0,0,0,0, 0,1,0,0,                    1,B+12,1,B+8,mem(B+8)));
    vec.push_back(mk(0,0,0,0, 0,1,1,mem(B+12),            0,B+12,1,B+8,mem(B+8)));
    vec.push_back(mk(0,0,0,0, 0,1,0,0,                    0,B+12,1,B+8,mem(B+8)));
    vec.push_back(mk(0,0,0,0, 1,1,0,0,                    0,B+12,1,B+8,mem(B+8)));
    vec.push_back(mk(0,0,0,0, 0,1,0,0,                    0,B+12,1,B+12,mem(B+12)));
    vec.push_back(mk(0,1,0,32'h80001000, 0,0,0,0,         1,B+16,1,B+12,mem(B+12)));
    vec.push_back(mk(0,0,0,0, 0,0,0,0,                    1,B+16,0,0,0));
    vec.push_back(mk(0,0,0,0, 0,0,0,0,                    1,B+16,0,0,0));
    vec.push_back(mk(0,0,0,0, 0,1,0,0,                    1,B+16,0,0,0));
    vec.push_back(mk(0,0,0,0, 0,1,1,mem(B+16),            0,B+16,0,0,0));
    vec.push_back(mk(0,0,0,0, 0,1,0,0,                    1,32'h80001000,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,1,1,mem(32'h80001000),    0,32'h80001000,0,0,0));
    vec.push_back(mk(1,1,32'hbfc00380,32'h80002000, 1,1,0,0,
                     1,32'h80001004,1,32'h80001000,mem(32'h80001000)));
    vec.push_back(mk(0,0,0,0, 1,1,1,mem(32'h80001004),    0,32'h80001004,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,1,0,0,                    1,32'hbfc00380,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,1,1,mem(32'hbfc00380),    0,32'hbfc00380,0,0,0));
    vec.push_back(mk(0,0,0,0, 1,0,0,0,
                     1,32'hbfc00384,1,32'hbfc00380,mem(32'hbfc00380)));

    do_reset();
    check("const_wr", {31'b0, inst_sram_wr}, 32'd0);
    check("const_size", {30'b0, inst_sram_size}, 32'd2);
    check("const_wstrb", {28'b0, inst_sram_wstrb}, 32'd0);
    check("const_wdata", inst_sram_wdata, 32'd0);
    for (int i = 0; i < vec.size(); i++) begin
      check($sformatf("vec%0d_req", i), {31'b0, inst_sram_req}, {31'b0, vec[i].e_req});
      check($sformatf("vec%0d_addr", i), inst_sram_addr, vec[i].e_addr);
      check($sformatf("vec%0d_fv", i), {31'b0, fs_valid}, {31'b0, vec[i].e_fv});
      if (vec[i].e_fv) begin
        check($sformatf("vec%0d_pc", i), fs_pc, vec[i].e_pc);
        check($sformatf("vec%0d_inst", i), fs_inst, vec[i].e_inst);
      end
      flush = vec[i].fl; br_taken = vec[i].br;
      flush_target = vec[i].ft; br_target = vec[i].bt;
      fs_allowin = vec[i].allow; inst_sram_addr_ok = vec[i].aok;
      inst_sram_data_ok = vec[i].dok; inst_sram_rdata = vec[i].rdata;
      @(posedge clk);
      @(negedge clk);
    end

    // Stalled decode: buffer fills, then requests stop.
    do_reset();
    aok_pct = 100; dly_min = 0; dly_max = 0; redir_pct = 0; allow_rnd = 0; allow = 0;
    repeat (10) tick();
    check("stall_accepts", accepts, 2);
    check("stall_req", {31'b0, inst_sram_req}, 32'd0);
    check("stall_fv", {31'b0, fs_valid}, 32'd1);
    check("stall_pc", fs_pc, B);
    allow = 1;
    repeat (20) tick();
    check("stall_resume", {31'b0, (pops >= 5)}, 32'd1);

    // Branch with two requests in flight.
    do_reset();
    dly_min = 3; dly_max = 3; wait_cnt = 3; allow = 1;
    budget = 0;
    while (respq.size() != 2 && budget < 30) begin
      tick();
      budget++;
    end
    check("br_two_outstanding", respq.size(), 2);
    p0 = pops;
    rd_br = 1; rd_bt = 32'h80001000;
    tick();
    budget = 0;
    while (pops == p0 && budget < 50) begin
      tick();
      budget++;
    end
    check("br_pop_seen", {31'b0, (pops > p0)}, 32'd1);
    check("br_next_exp", exp_pc, 32'h80001004);

    // Address wrap at the top of the space.
    p0 = pops;
    dly_min = 0; dly_max = 1;
    rd_br = 1; rd_bt = 32'hfffffff8;
    tick();
    budget = 0;
    while (pops < p0 + 3 && budget < 100) begin
      tick();
      budget++;
    end
    check("wrap_pops", {31'b0, (pops >= p0 + 3)}, 32'd1);

    // Random delays, stalls and redirects.
    do_reset();
    aok_pct = 50; dly_min = 0; dly_max = 5; redir_pct = 2; allow_rnd = 1;
    repeat (10000) tick();
    check("rand_max_outstanding", {31'b0, (max_out <= 2)}, 32'd1);
    check("rand_progress", {31'b0, (pops > 1000)}, 32'd1);

    // Reset in the middle of traffic, then clean restart.
    do_reset();
    aok_pct = 100; dly_min = 0; dly_max = 2; redir_pct = 0; allow_rnd = 0; allow = 1;
    repeat (30) tick();
    check("post_reset_progress", {31'b0, (pops >= 4)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
